uart_frame_rx: RTL



---
 rtl/uart_frame_rx.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
//
// Purpose:
//   Sits behind a UART receiver and turns its byte stream into checked packets.
//   A packet on the wire is:  SYNC, LEN, LEN payload bytes, CSUM.
//   The payload is buffered while the frame arrives. The additive checksum
//   (LEN + payload + CSUM, mod 256) must equal zero. A good payload is then
//   replayed on a valid/ready stream. A bad frame is dropped and reported
//   with an error code.
//
// Optional feature (compile-time macro):
//   UART_FRAME_TIMEOUT_EN - enables an inter-byte idle timeout of
//                           TIMEOUT_CYCLES clocks while a frame is open.
//                           Without it, a partial frame waits indefinitely.
//
// Ports:
//   i_clk        system clock
//   i_resetn     synchronous, active-low reset
//   i_rx_valid   one-cycle pulse: i_rx_data holds a received byte
//   i_rx_data    received byte
//   i_rx_break   one-cycle pulse, coincident with i_rx_valid: BREAK detected
//   o_out_valid  payload byte available on o_out_data
//   i_out_ready  consumer accepts the byte this cycle
//   o_out_data   payload byte
//   o_out_last   final payload byte of the frame
//   o_frame_ok   one-cycle pulse: frame passed its checksum
//   o_err_valid  one-cycle pulse: frame aborted, reason in o_err_code
//   o_err_code   1 = LEN > MAX_LEN, 2 = checksum fail, 3 = break/timeout.
//                Holds the last reported code.
//   o_overrun    one-cycle pulse: byte dropped because it arrived during drain
//   o_dbg_state  current FSM state (S_SYNC=0, S_LEN=1, S_PAY=2, S_CSUM=3,
//                S_DRAIN=4)
//
// Output handshake:
//   A byte moves when o_out_valid && i_out_ready at a rising clock edge.
//   Once o_out_valid is high, o_out_valid, o_out_data and o_out_last hold
//   steady until that transfer happens. o_out_valid never depends
//   combinationally on i_out_ready. There is no back-pressure toward the UART.
//   Any byte arriving while the payload drains is dropped and flagged on
//   o_overrun.
// -----------------------------------------------------------------------------
module uart_frame_rx #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_break,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_out_data,
  output logic       o_out_last,
  output logic       o_frame_ok,
  output logic       o_err_valid,
  output logic [1:0] o_err_code,
  output logic       o_overrun,
  output logic [2:0] o_dbg_state
);

  // Pointer width covers 0..MAX_LEN. The buffer depth is rounded up to the
  // next power of two, so a pointer indexes the array without range checks.
  localparam int         PTR_W     = $clog2(MAX_LEN + 1);
  localparam int         BUF_DEPTH = 1 << PTR_W;
  localparam logic [8:0] MAX_LEN_9 = 9'(MAX_LEN);
  localparam logic [PTR_W-1:0] PTR_ZERO = '0;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [2:0] S_SYNC  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_PAY   = 3'd2;
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [1:0] E_LEN   = 2'd1;
  localparam logic [1:0] E_CSUM  = 2'd2;
  localparam logic [1:0] E_ABORT = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]       r_state;
  logic [7:0]       r_len;
  logic [7:0]       r_sum;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_last;
  logic             r_frame_ok;
  logic             r_err_valid;
  logic [1:0]       r_err_code;
  logic             r_overrun;
  logic [7:0]       r_buf [BUF_DEPTH];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic             w_in_frame;
  logic             w_byte;
  logic             w_break;
  logic             w_timeout;
  logic             w_abort;
  logic             w_handshake;
  logic [7:0]       w_csum_total;
  logic [PTR_W-1:0] w_wr_next;
  logic [PTR_W-1:0] w_rd_next;

  assign w_in_frame   = (r_state == S_LEN) || (r_state == S_PAY) ||
                        (r_state == S_CSUM);
  // A byte tagged with BREAK is never treated as data.
  assign w_byte       = i_rx_valid && !i_rx_break;
  assign w_break      = i_rx_valid && i_rx_break;
  assign w_abort      = w_in_frame && (w_break || w_timeout);
  assign w_handshake  = r_out_valid && i_out_ready;
  assign w_csum_total = r_sum + i_rx_data;
  assign w_wr_next    = r_wr_ptr + PTR_ONE;
  assign w_rd_next    = r_rd_ptr + PTR_ONE;

  // ---------------------------------------------------------------------------
  // Optional inter-byte timeout
  // ---------------------------------------------------------------------------
`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_idle;

  // The counter restarts on every received byte. Entry to S_LEN is itself
  // caused by a received byte, so that entry also restarts it. It counts
  // only while a frame is open. The abort fires on the cycle the count
  // would reach TIMEOUT_CYCLES.
  always_ff @(posedge i_clk) begin
    if (!i_resetn || !w_in_frame || i_rx_valid) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + TMO_W'(1);
    end
  end

  assign w_timeout = w_in_frame && !i_rx_valid &&
                     (r_idle == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Payload buffer (no reset: contents only matter once written)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_resetn && (r_state == S_PAY) && w_byte && !w_timeout) begin
      r_buf[r_wr_ptr] <= i_rx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state     <= S_SYNC;
      r_len       <= 8'd0;
      r_sum       <= 8'd0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'd0;
      r_out_last  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= 2'd0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_ok  <= 1'b0;
      r_err_valid <= 1'b0;
      r_overrun   <= 1'b0;

      if (w_abort) begin
        // Break or timeout inside an open frame. The coincident byte is
        // not consumed.
        r_state     <= S_SYNC;
        r_err_valid <= 1'b1;
        r_err_code  <= E_ABORT;
      end else begin
        case (r_state)
          S_SYNC: begin
            if (w_byte && (i_rx_data == SYNC_BYTE)) begin
              r_state <= S_LEN;
            end
          end

          S_LEN: begin
            if (w_byte) begin
              r_len    <= i_rx_data;
              r_sum    <= i_rx_data;
              r_wr_ptr <= '0;
              if ({1'b0, i_rx_data} > MAX_LEN_9) begin
                r_state     <= S_SYNC;
                r_err_valid <= 1'b1;
                r_err_code  <= E_LEN;
              end else if (i_rx_data == 8'd0) begin
                r_state <= S_CSUM;
              end else begin
                r_state <= S_PAY;
              end
            end
          end

          S_PAY: begin
            // SYNC_BYTE here is ordinary payload. Only the byte count
            // ends this state.
            if (w_byte) begin
              r_sum    <= r_sum + i_rx_data;
              r_wr_ptr <= w_wr_next;
              if (8'(w_wr_next) == r_len) begin
                r_state <= S_CSUM;
              end
            end
          end

          S_CSUM: begin
            if (w_byte) begin
              if (w_csum_total == 8'd0) begin
                r_frame_ok <= 1'b1;
                if (r_len == 8'd0) begin
                  r_state <= S_SYNC;
                end else begin
                  // Present the first payload byte straight away, so
                  // o_out_valid rises the cycle after the CSUM byte.
                  r_state     <= S_DRAIN;
                  r_out_valid <= 1'b1;
                  r_out_data  <= r_buf[PTR_ZERO];
                  r_out_last  <= (r_len == 8'd1);
                  r_rd_ptr    <= '0;
                end
              end else begin
                r_state     <= S_SYNC;
                r_err_valid <= 1'b1;
                r_err_code  <= E_CSUM;
              end
            end
          end

          S_DRAIN: begin
            // A plain byte or a break arriving now has nowhere to go.
            if (i_rx_valid) begin
              r_overrun <= 1'b1;
            end
            if (w_handshake) begin
              if (r_out_last) begin
                r_state     <= S_SYNC;
                r_out_valid <= 1'b0;
                r_rd_ptr    <= '0;
              end else begin
                r_rd_ptr   <= w_rd_next;
                r_out_data <= r_buf[w_rd_next];
                // w_rd_next is below r_len here, so the +1 cannot wrap.
                r_out_last <= ((8'(w_rd_next) + 8'd1) == r_len);
              end
            end
          end

          default: begin
            r_state     <= S_SYNC;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_frame_ok  = r_frame_ok;
  assign o_err_valid = r_err_valid;
  assign o_err_code  = r_err_code;
  assign o_overrun   = r_overrun;
  assign o_dbg_state = r_state;

endmodule
